// File: rtl/lcd_nibble_receiver_pkg.sv
// lcd_pkg: shared states, command opcodes, control bit positions and line bases for the LCD receiver
package lcd_pkg;
  typedef enum logic [1:0] {INIT, RUN, CLEAR} state_t;
  localparam logic [7:0] CMD_CLEAR = 8'h01;
  localparam logic [7:0] CMD_HOME = 8'h02;
  localparam logic [7:0] CMD_ENTRY = 8'h04;
  localparam logic [7:0] CMD_FUNC = 8'h20;
  localparam logic [7:0] CMD_DDRAM = 8'h80;
  localparam int RS = 2;
  localparam int RW = 1;
  localparam int E = 0;
  localparam logic [6:0] LINE0_BASE = 7'h00;
  localparam logic [6:0] LINE1_BASE = 7'h40;
  function automatic logic [7:0] top_bit(input logic [7:0] b);
    top_bit = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) top_bit = 8'(1) << i;
  endfunction
endpackage

// File: rtl/lcd_bus_sync.sv
// lcd_bus_sync: synchronises the LCD bus and strobes a sample on each falling edge of E
module lcd_bus_sync
  import lcd_pkg::*;
#(
  parameter int N = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] datain,
  input  logic [2:0] control,
  output logic [3:0] nib,
  output logic       rs,
  output logic       rw,
  output logic       e,
  output logic       stb
);
  logic [N-1:0][6:0] sr;
  logic e_q;
  // shift bus through the synchroniser chain and remember last synchronised E
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sr <= '0;
      e_q <= 1'b0;
    end else begin
      sr <= {sr[N-2:0], datain, control};
      e_q <= e;
    end
  // sample values are whatever is synchronised in the E-fall cycle
  always_comb begin
    nib = sr[N-1][6:3];
    rs = sr[N-1][RS];
    rw = sr[N-1][RW];
    e = sr[N-1][E];
    stb = e_q & ~e;
  end
endmodule

// File: rtl/lcd_nibble_receiver.sv
// lcd_nibble_receiver: HD44780-style 4-bit bus receiver with init handshake, command subset and DDRAM write port
module lcd_nibble_receiver
  import lcd_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int CLR_CYCLES = 32
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [3:0] datain,
  input  logic [2:0] control,
  output logic [3:0] rd_data,
  output logic       rd_oe,
  output logic [7:0] byte_out,
  output logic       byte_rs,
  output logic       byte_valid,
  output logic       ram_we,
  output logic [4:0] ram_addr,
  output logic [7:0] ram_wdata,
  output logic       busy,
  output logic       mode4
);
  logic [3:0] nib, hi_nib;
  logic rs, rw, e, stb, wr, rd, phase, hi_rs, inc;
  logic [4:0] addr;
  logic [15:0] cnt;
  logic [7:0] hb;
  logic [6:0] ddram;
  state_t state, nxt;
  lcd_bus_sync #(.N(SYNC_STAGES)) u_sync (
    .clk(CLK),
    .rst(RST),
    .datain(datain),
    .control(control),
    .nib(nib),
    .rs(rs),
    .rw(rw),
    .e(e),
    .stb(stb)
  );
  // next state, busy flag and read-back nibble
  always_comb begin
    wr = stb & ~rw;
    rd = stb & rw;
    hb = top_bit(byte_out);
    ddram = (addr[4] ? LINE1_BASE : LINE0_BASE) | {3'b000, addr[3:0]};
    nxt = state;
    if (state == INIT && wr && !rs && nib == CMD_FUNC[7:4]) nxt = RUN;
    if (state == RUN && byte_valid && !byte_rs && hb == CMD_CLEAR) nxt = CLEAR;
    if (state == CLEAR && cnt == 16'(CLR_CYCLES - 1)) nxt = RUN;
    busy = state == CLEAR;
    rd_oe = e & rw;
    rd_data = rd_oe ? (phase ? ddram[3:0] : {busy, ddram[6:4]}) : 4'h0;
  end
  // controller state register
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= INIT;
    else state <= nxt;
  // nibble pairing, command execution, address stepping and clear fill
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      phase <= 1'b0;
      hi_nib <= '0;
      hi_rs <= 1'b0;
      addr <= '0;
      inc <= 1'b1;
      cnt <= '0;
      mode4 <= 1'b0;
      byte_out <= '0;
      byte_rs <= 1'b0;
      byte_valid <= 1'b0;
      ram_we <= 1'b0;
      ram_addr <= '0;
      ram_wdata <= '0;
    end else begin
      byte_valid <= 1'b0;
      ram_we <= 1'b0;
      cnt <= state == CLEAR ? cnt + 16'd1 : '0;
      if (state == INIT && nxt == RUN) mode4 <= 1'b1;
      if (state == RUN && wr && !phase) begin
        hi_nib <= nib;
        hi_rs <= rs;
        phase <= 1'b1;
      end
      if (state == RUN && wr && phase) begin
        byte_out <= {hi_nib, nib};
        byte_rs <= hi_rs;
        byte_valid <= 1'b1;
        phase <= 1'b0;
        ram_we <= hi_rs;
        ram_addr <= addr;
        ram_wdata <= {hi_nib, nib};
      end
      if (state != INIT && rd) phase <= ~phase;
      if (state == CLEAR && cnt < 16'd32) begin
        ram_we <= 1'b1;
        ram_addr <= cnt[4:0];
        ram_wdata <= 8'h20;
      end
      if (state == RUN && byte_valid) begin
        if (byte_rs) addr <= inc ? addr + 5'd1 : addr - 5'd1;
        else if (hb == CMD_DDRAM) addr <= {byte_out[6], byte_out[3:0]};
        else if (hb == CMD_ENTRY) inc <= byte_out[1];
        else if (hb == CMD_HOME) addr <= '0;
        else if (hb == CMD_CLEAR) begin
          addr <= '0;
          inc <= 1'b1;
        end
      end
    end
endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// tb_lcd_nibble_receiver: directed bus transactions against hand-computed DDRAM writes, bytes and read-backs
module tb_lcd_nibble_receiver;
  logic CLK = 1'b0, RST = 1'b1;
  logic [3:0] datain = '0;
  logic [2:0] control = '0;
  logic [3:0] rd_data;
  logic rd_oe, byte_rs, byte_valid, ram_we, busy, mode4;
  logic [7:0] byte_out, ram_wdata;
  logic [4:0] ram_addr;
  int n_cmp = 0, n_bad = 0;
  int ram_n = 0, bv_n = 0, busy_n = 0;
  logic [4:0] ram_a[256];
  logic [7:0] ram_d[256];
  logic [7:0] last_b = '0;
  logic last_rs = 1'b0;

  lcd_nibble_receiver dut (
    .CLK(CLK), .RST(RST), .datain(datain), .control(control),
    .rd_data(rd_data), .rd_oe(rd_oe), .byte_out(byte_out), .byte_rs(byte_rs),
    .byte_valid(byte_valid), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .busy(busy), .mode4(mode4)
  );

  always #5 CLK = ~CLK;

  // log DDRAM writes, assembled bytes and busy cycles away from the active edge
  always @(negedge CLK) begin
    if (ram_we) begin
      ram_a[ram_n[7:0]] = ram_addr;
      ram_d[ram_n[7:0]] = ram_wdata;
      ram_n++;
    end
    if (byte_valid) begin
      last_b = byte_out;
      last_rs = byte_rs;
      bv_n++;
    end
    if (busy) busy_n++;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic rs, input logic rw, input logic [3:0] nib,
                       output logic [3:0] rd, output logic oe);
    @(negedge CLK);
    datain = nib;
    control = {rs, rw, 1'b0};
    repeat (2) @(negedge CLK);
    control[0] = 1'b1;
    repeat (4) @(negedge CLK);
    rd = rd_data;
    oe = rd_oe;
    control[0] = 1'b0;
    repeat (8) @(negedge CLK);
    control = '0;
  endtask

  task automatic wnib(input logic rs, input logic [3:0] nib);
    logic [3:0] r;
    logic o;
    pulse(rs, 1'b0, nib, r, o);
  endtask

  task automatic wbyte(input logic rs, input logic [7:0] b);
    wnib(rs, b[7:4]);
    wnib(rs, b[3:0]);
  endtask

  task automatic init_seq();
    wnib(1'b0, 4'h3);
    wnib(1'b0, 4'h3);
    wnib(1'b0, 4'h3);
    check("init_pre_mode4", int'(mode4), 0);
    wnib(1'b0, 4'h2);
    check("init_mode4", int'(mode4), 1);
  endtask

  task automatic rd_pair(input string tag, input logic [3:0] eh, input logic [3:0] el);
    logic [3:0] h, l;
    logic oh, ol;
    pulse(1'b0, 1'b1, 4'h0, h, oh);
    pulse(1'b0, 1'b1, 4'h0, l, ol);
    check({tag, "_hi"}, int'(h), int'(eh));
    check({tag, "_lo"}, int'(l), int'(el));
    check({tag, "_oe"}, int'(oh & ol), 1);
  endtask

  task automatic ram_chk(input string tag, input int idx, input int a, input int d);
    check({tag, "_addr"}, int'(ram_a[idx[7:0]]), a);
    check({tag, "_data"}, int'(ram_d[idx[7:0]]), d);
  endtask

  initial begin
    int b0, bb, bvb, errs;
    logic [3:0] h;
    logic oh;
    repeat (3) @(negedge CLK);
    check("rst_mode4", int'(mode4), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_rd_oe", int'(rd_oe), 0);
    check("rst_byte_valid", int'(byte_valid), 0);
    check("rst_ram_we", int'(ram_we), 0);
    check("rst_byte_out", int'(byte_out), 0);
    RST = 1'b0;
    init_seq();
    check("init_no_bytes", bv_n, 0);

    b0 = ram_n;
    wbyte(1'b0, 8'h80);
    wbyte(1'b1, 8'h41);
    wbyte(1'b1, 8'h42);
    check("data_count", ram_n - b0, 2);
    ram_chk("data0", b0, 0, 'h41);
    ram_chk("data1", b0 + 1, 1, 'h42);
    check("data_rs", int'(last_rs), 1);
    check("data_bytes", bv_n, 3);

    b0 = ram_n;
    wbyte(1'b0, 8'h8F);
    wbyte(1'b1, 8'h5A);
    wbyte(1'b1, 8'h5B);
    ram_chk("wrap15", b0, 15, 'h5A);
    ram_chk("wrap16", b0 + 1, 16, 'h5B);
    b0 = ram_n;
    wbyte(1'b0, 8'hCF);
    wbyte(1'b1, 8'h11);
    ram_chk("wrap31", b0, 31, 'h11);
    rd_pair("wrap_addr0", 4'h0, 4'h0);

    wbyte(1'b0, 8'h04);
    wbyte(1'b0, 8'h80);
    b0 = ram_n;
    wbyte(1'b1, 8'h01);
    wbyte(1'b1, 8'h02);
    ram_chk("dec0", b0, 0, 'h01);
    ram_chk("dec31", b0 + 1, 31, 'h02);
    rd_pair("dec_addr30", 4'h4, 4'hE);
    wbyte(1'b0, 8'h06);

    wbyte(1'b0, 8'hC5);
    rd_pair("rd_c5", 4'h4, 4'h5);
    wbyte(1'b0, 8'h02);
    rd_pair("home", 4'h0, 4'h0);
    wbyte(1'b0, 8'hC3);

    b0 = ram_n;
    bb = busy_n;
    bvb = bv_n;
    wbyte(1'b0, 8'h01);
    wnib(1'b1, 4'h7);
    repeat (40) @(negedge CLK);
    check("clr_busy_cycles", busy_n - bb, 32);
    check("clr_writes", ram_n - b0, 32);
    errs = 0;
    for (int i = 0; i < 32; i++)
      if (int'(ram_a[(b0 + i) % 256]) != i || ram_d[(b0 + i) % 256] != 8'h20) errs++;
    check("clr_fill_errs", errs, 0);
    check("clr_drop_byte", bv_n - bvb, 1);
    check("clr_done_busy", int'(busy), 0);
    b0 = ram_n;
    wbyte(1'b1, 8'h33);
    check("clr_after_count", ram_n - b0, 1);
    ram_chk("clr_after", b0, 0, 'h33);

    wbyte(1'b0, 8'h01);
    pulse(1'b0, 1'b1, 4'h0, h, oh);
    check("clr_rd_hi", int'(h), 'h8);
    repeat (40) @(negedge CLK);
    pulse(1'b0, 1'b1, 4'h0, h, oh);
    check("clr_rd_lo", int'(h), 'h0);
    check("clr_rd_busy", int'(busy), 0);

    wnib(1'b1, 4'hA);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("mid_rst_mode4", int'(mode4), 0);
    RST = 1'b0;
    init_seq();
    b0 = ram_n;
    wbyte(1'b0, 8'h80);
    wbyte(1'b1, 8'h61);
    check("mid_rst_count", ram_n - b0, 1);
    ram_chk("mid_rst", b0, 0, 'h61);
    check("mid_rst_byte", int'(last_b), 'h61);
    rd_pair("mid_rst_addr1", 4'h0, 4'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
